// File: rtl/mac_stream_driver_if.sv
// Handshake and operand bundle for mac_stream_driver.
// Carries the optional bias input when MAC_BIAS_EN is defined.
interface mac_stream_driver_if;
  logic        start;
  logic [7:0]  len;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [31:0] mac_c;
  logic [31:0] mac_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
`ifdef MAC_BIAS_EN
  logic [31:0] bias;
`endif

  // Environment side: requester, operand source, MAC core and result sink.
  modport master (
    output start, len, abort, in_valid, in_a, in_b, mac_y, out_ready,
`ifdef MAC_BIAS_EN
    output bias,
`endif
    input  in_ready, mac_a, mac_b, mac_c, out_valid, out_data, busy
  );

  modport slave (
    input  start, len, abort, in_valid, in_a, in_b, mac_y, out_ready,
`ifdef MAC_BIAS_EN
    input  bias,
`endif
    output in_ready, mac_a, mac_b, mac_c, out_valid, out_data, busy
  );
endinterface

// File: rtl/mac_stream_driver.sv
// Sequences fp16 operand pairs through an external fixed-latency MAC and returns the fp32 sum.
// Define MAC_BIAS_EN to seed the accumulator from the bias input instead of zero.
module mac_stream_driver #(
  parameter int unsigned MAC_LAT = 3
) (
  input logic                CLK,
  input logic                RESETn,
  mac_stream_driver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [3:0] LAT = MAC_LAT[3:0];

  state_e      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] mac_a_q, mac_a_d;
  logic [15:0] mac_b_q, mac_b_d;
  logic [31:0] mac_c_q, mac_c_d;
  logic [31:0] init_val;

`ifdef MAC_BIAS_EN
  assign init_val = bus.bias;
`else
  assign init_val = 32'h0000_0000;
`endif

  always_comb begin
    // NOTE: every target gets its hold value first, so no path through the case can infer a latch.
    state_d = state_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    acc_d   = acc_q;
    mac_a_d = mac_a_q;
    mac_b_d = mac_b_q;
    mac_c_d = mac_c_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = init_val;
          if (bus.len == 8'd0) begin
            state_d = DONE;
          end else begin
            rem_d   = bus.len;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.in_valid) begin
          mac_a_d = bus.in_a;
          mac_b_d = bus.in_b;
          mac_c_d = acc_q;
          rem_d   = rem_q - 8'd1;
          wait_d  = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q - 4'd1;
          // wait_q==1 marks the MAC_LAT-th edge after issue, where mac_y is valid.
          if (wait_q == 4'd1) begin
            acc_d   = bus.mac_y;
            state_d = (rem_q == 8'd0) ? DONE : ISSUE;
          end
        end
      end
      DONE: begin
        if (bus.abort || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wait_q  <= '0;
      acc_q   <= '0;
      mac_a_q <= '0;
      mac_b_q <= '0;
      mac_c_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      acc_q   <= acc_d;
      mac_a_q <= mac_a_d;
      mac_b_q <= mac_b_d;
      mac_c_q <= mac_c_d;
    end
  end

  assign bus.in_ready  = (state_q == ISSUE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = acc_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_c     = mac_c_q;

endmodule

// File: tb/tb_mac_stream_driver.sv
// Self-checking bench for mac_stream_driver: real-valued dot-product model plus directed jobs.
// Emulates the external MAC with a MAC_LAT-deep result history fed from mac_a/mac_b/mac_c.
`timescale 1ns/1ps
module tb_mac_stream_driver;

  localparam int MAC_LAT = 3;

`ifdef MAC_BIAS_EN
  localparam logic [31:0] INIT_BITS = 32'h3F80_0000;
  localparam logic [31:0] E1_C0 = 32'h3F80_0000, E1_C1 = 32'h4040_0000, E1_Y = 32'h40E0_0000;
  localparam logic [31:0] E3_Y  = 32'h4120_0000, E4_Y  = 32'h4120_0000;
  localparam logic [31:0] E5_Y  = 32'h4000_0000, E6_Y  = 32'h4040_0000;
`else
  localparam logic [31:0] INIT_BITS = 32'h0000_0000;
  localparam logic [31:0] E1_C0 = 32'h0000_0000, E1_C1 = 32'h4000_0000, E1_Y = 32'h40C0_0000;
  localparam logic [31:0] E3_Y  = 32'h4110_0000, E4_Y  = 32'h4110_0000;
  localparam logic [31:0] E5_Y  = 32'h3F80_0000, E6_Y  = 32'h4000_0000;
`endif

  logic CLK = 1'b0;
  logic RESETn = 1'b1;
  always #5 CLK = ~CLK;

  mac_stream_driver_if bus();

  mac_stream_driver #(.MAC_LAT(MAC_LAT)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting, got 0 want 1 at %0t", name, $time);
  endtask

  // ---------------- floating-point helpers (exact for the small values used) ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_to_real(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real m = real'(h[9:0]);
    real r;
    if (e == 0) r = m * pow2(-24);
    else        r = (1.0 + m / 1024.0) * pow2(e - 15);
    return h[15] ? -r : r;
  endfunction

  function automatic real fp32_to_real(input logic [31:0] w);
    int  e = int'(w[30:23]);
    real m = real'(w[22:0]);
    real r;
    if (e == 0) r = m * pow2(-149);
    else        r = (1.0 + m / 8388608.0) * pow2(e - 127);
    return w[31] ? -r : r;
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    logic        s;
    int          e = 0;
    real         m;
    logic [7:0]  ef;
    logic [22:0] mf;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    ef = 8'(e + 127);
    mf = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, ef, mf};
  endfunction

  function automatic logic [31:0] mac_f(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c);
    return real_to_fp32(fp16_to_real(a) * fp16_to_real(b) + fp32_to_real(c));
  endfunction

  // ---------------- external MAC emulation ----------------
  logic [31:0] hist [16] = '{default: '0};
  always @(negedge CLK) begin
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0]   = mac_f(bus.mac_a, bus.mac_b, bus.mac_c);
    bus.mac_y = hist[MAC_LAT-1];
  end

  // ---------------- behavioural model ----------------
  bit          m_busy, m_ready, m_ovalid;
  int          m_left, m_gap;
  real         m_sum;
  logic [31:0] m_out;
  logic [15:0] m_a, m_b;
  logic [31:0] m_c;

  function automatic void model_reset();
    m_busy = 0; m_ready = 0; m_ovalid = 0;
    m_left = 0; m_gap = 0; m_sum = 0.0;
    m_out = '0; m_a = '0; m_b = '0; m_c = '0;
  endfunction

  function automatic logic [31:0] init_bits();
`ifdef MAC_BIAS_EN
    return bus.bias;
`else
    return 32'h0;
`endif
  endfunction

  // One clock edge worth of job progress: rules of the dot-product protocol.
  function automatic void model_step();
    if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1;
        m_sum  = fp32_to_real(init_bits());
        if (bus.len == 8'd0) begin
          m_ovalid = 1;
          m_out    = init_bits();
        end else begin
          m_left  = int'(bus.len);
          m_ready = 1;
        end
      end
    end else if (bus.abort) begin
      m_busy = 0; m_ready = 0; m_ovalid = 0; m_gap = 0;
    end else if (m_ovalid) begin
      if (bus.out_ready) begin
        m_busy = 0; m_ovalid = 0;
      end
    end else if (m_ready) begin
      if (bus.in_valid) begin
        m_a     = bus.in_a;
        m_b     = bus.in_b;
        m_c     = real_to_fp32(m_sum);
        m_sum   = m_sum + fp16_to_real(bus.in_a) * fp16_to_real(bus.in_b);
        m_left  = m_left - 1;
        m_ready = 0;
        m_gap   = MAC_LAT;
      end
    end else begin
      m_gap = m_gap - 1;
      if (m_gap == 0) begin
        if (m_left == 0) begin
          m_ovalid = 1;
          m_out    = real_to_fp32(m_sum);
        end else begin
          m_ready = 1;
        end
      end
    end
  endfunction

  always @(negedge RESETn) model_reset();
  always @(posedge CLK) begin
    if (!RESETn) model_reset();
    else         model_step();
  end

  int hs_count = 0;
  always @(posedge CLK) if (RESETn && bus.in_valid && bus.in_ready) hs_count++;

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    check("in_ready",  32'(bus.in_ready),  32'(m_ready));
    check("out_valid", 32'(bus.out_valid), 32'(m_ovalid));
    check("busy",      32'(bus.busy),      32'(m_busy));
    check("mac_a",     32'(bus.mac_a),     32'(m_a));
    check("mac_b",     32'(bus.mac_b),     32'(m_b));
    check("mac_c",     bus.mac_c,          m_c);
    if (m_ovalid) check("out_data", bus.out_data, m_out);
  end

  // ---------------- directed stimulus ----------------
  task automatic start_job(input logic [7:0] n);
    @(negedge CLK);
    bus.start = 1'b1;
    bus.len   = n;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.in_ready) begin
      timeout("in_ready");
    end else begin
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      @(negedge CLK);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.out_valid) timeout(name);
    else                check(name, bus.out_data, exp);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    check("busy after release", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin
    bus.start = 0; bus.len = '0; bus.abort = 0;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 0;
`ifdef MAC_BIAS_EN
    bus.bias = INIT_BITS;
`endif
    #1 RESETn = 1'b0;
    #1;
    check("reset mac_c",    bus.mac_c,    32'h0);
    check("reset out_data", bus.out_data, 32'h0);
    check("reset busy",     32'(bus.busy), 32'd0);
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);

    // Two-pair dot product: 1*2 + 2*2.
    start_job(8'd2);
    send_pair(16'h3C00, 16'h4000);
    check("job1 mac_c first", bus.mac_c, E1_C0);
    send_pair(16'h4000, 16'h4000);
    check("job1 mac_c second", bus.mac_c, E1_C1);
    wait_done("job1 result", E1_Y);
    release_result();

    // Zero-length job completes immediately with the initial value.
    @(negedge CLK);
    bus.start = 1'b1;
    bus.len   = 8'd0;
    @(negedge CLK);
    bus.start = 1'b0;
    check("len0 out_valid", 32'(bus.out_valid), 32'd1);
    check("len0 out_data",  bus.out_data, INIT_BITS);
    check("len0 in_ready",  32'(bus.in_ready), 32'd0);
    release_result();

    // Three pairs with 5-cycle gaps on in_valid: 1*1 + 2*3 + 0.5*4.
    hs_count = 0;
    start_job(8'd3);
    send_pair(16'h3C00, 16'h3C00);
    repeat (5) @(negedge CLK);
    send_pair(16'h4000, 16'h4200);
    repeat (5) @(negedge CLK);
    send_pair(16'h3800, 16'h4400);
    wait_done("gap job result", E3_Y);
    check("gap job handshakes", 32'(hs_count), 32'd3);
    release_result();

    // Result held for 10 cycles with out_ready low while start pulses are ignored.
    start_job(8'd1);
    send_pair(16'h4200, 16'h4200);
    wait_done("hold job result", E4_Y);
    for (int i = 0; i < 10; i++) begin
      bus.start = (i % 2 == 0);
      bus.len   = 8'd5;
      @(negedge CLK);
      check("hold out_valid", 32'(bus.out_valid), 32'd1);
      check("hold out_data",  bus.out_data, E4_Y);
    end
    bus.start = 1'b0;
    release_result();

    // Abort during the wait of pair 2 of 4, then a fresh job started alongside abort.
    start_job(8'd4);
    send_pair(16'h3C00, 16'h3C00);
    send_pair(16'h3C00, 16'h3C00);
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
    check("abort busy",      32'(bus.busy), 32'd0);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    repeat (6) @(negedge CLK);
    bus.start = 1'b1;
    bus.len   = 8'd1;
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start with idle abort", 32'(bus.busy), 32'd1);
    send_pair(16'h4000, 16'h3800);
    wait_done("post-abort result", E5_Y);
    release_result();

    // Asynchronous reset in the middle of a wait.
    start_job(8'd1);
    send_pair(16'h4400, 16'h4400);
    @(posedge CLK);
    #2 RESETn = 1'b0;
    #1;
    check("async mac_a",     32'(bus.mac_a), 32'h0);
    check("async mac_b",     32'(bus.mac_b), 32'h0);
    check("async mac_c",     bus.mac_c, 32'h0);
    check("async out_data",  bus.out_data, 32'h0);
    check("async busy",      32'(bus.busy), 32'd0);
    check("async in_ready",  32'(bus.in_ready), 32'd0);
    check("async out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    check("post-reset busy", 32'(bus.busy), 32'd0);

    // Block still works after reset: 1*2.
    start_job(8'd1);
    send_pair(16'h3C00, 16'h4000);
    wait_done("post-reset result", E6_Y);
    release_result();

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
